// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM encoding, miss limit, defaults.
// Optional parity slot is enabled by defining TDM_DEMUX_PARITY_EN.
package tdm_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MISS_LIMIT      = 2;
    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_SLOT_CYCLES = 4;

    // Slots per frame, including the trailing parity slot when it is compiled in.
    function automatic int unsigned nslot(input int unsigned num_ch);
`ifdef TDM_DEMUX_PARITY_EN
        return num_ch + 1;
`else
        return num_ch;
`endif
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Cycle-within-slot and slot-within-frame counters with sample and frame-boundary strobes.
// Counters sit at zero while disabled and restart from zero on clr.
module tdm_slot_counter #(
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned NSLOT       = 4,
    localparam int unsigned SW         = $clog2(NSLOT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [SW-1:0] slot,
    output logic          sample,
    output logic          boundary
);

    localparam int unsigned CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_MID   = CW'(SLOT_CYCLES / 2);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOT - 1);

    logic [CW-1:0] cyc;
    logic          cyc_wrap;

    assign cyc_wrap = (cyc == CYC_LAST);
    assign sample   = en && (cyc == CYC_MID);
    assign boundary = en && cyc_wrap && (slot == SLOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  <= '0;
            slot <= '0;
        end else if (!en || clr) begin
            cyc  <= '0;
            slot <= '0;
        end else if (cyc_wrap) begin
            cyc  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer with sync tracking, flywheel and loss-of-lock.
// Define TDM_DEMUX_PARITY_EN to add a trailing even-parity slot per frame.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] ch_out,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err,
    output logic              parity_err
);

    localparam int unsigned NSLOT = nslot(NUM_CH);
    localparam int unsigned SW    = $clog2(NSLOT);

    state_t           state;
    logic [1:0]       miss;
    logic [NSLOT-1:0] shadow;
    logic [NSLOT-1:0] frame_bits;
    logic [SW-1:0]    slot;
    logic             sample;
    logic             boundary;
    logic             par_ok;

    tdm_slot_counter #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NSLOT       (NSLOT)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == RUN),
        .clr      (frame_sync),
        .slot     (slot),
        .sample   (sample),
        .boundary (boundary)
    );

    // With two-cycle slots the last sample lands on the boundary cycle itself.
    always_comb begin
        frame_bits = shadow;
        if (sample) begin
            frame_bits[slot] = din;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    assign par_ok = ~^frame_bits;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            miss        <= '0;
            shadow      <= '0;
            ch_out      <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (frame_sync) begin
                        state  <= RUN;
                        locked <= 1'b1;
                        miss   <= '0;
                        shadow <= '0;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        shadow <= '0;
                        if (par_ok) begin
                            ch_out      <= frame_bits[NUM_CH-1:0];
                            frame_valid <= 1'b1;
                        end
`ifdef TDM_DEMUX_PARITY_EN
                        else begin
                            parity_err <= 1'b1;
                        end
`endif
                        // Flywheel over missing syncs until the limit is reached.
                        if (frame_sync) begin
                            miss <= '0;
                        end else if (miss == 2'(MISS_LIMIT - 1)) begin
                            state  <= IDLE;
                            locked <= 1'b0;
                            miss   <= '0;
                        end else begin
                            miss <= miss + 2'd1;
                        end
                    end else if (frame_sync) begin
                        sync_err <= 1'b1;
                        shadow   <= '0;
                    end else begin
                        shadow <= frame_bits;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NUM_CH=4, SLOT_CYCLES=4).
// Parity scenarios are compiled in when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif
    localparam int FRAME = NSLOT * 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       frame_sync;
    logic [3:0] ch_out;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic       parity_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int fv_cnt      = 0;
    int se_cnt      = 0;
    int pe_cnt      = 0;
    int fv_last     = 0;
    int fv_prev     = 0;
    int base;

    tdm_demux #(
        .NUM_CH      (4),
        .SLOT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .frame_sync  (frame_sync),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc_n++;
        if (frame_valid) begin
            fv_cnt++;
            fv_prev = fv_last;
            fv_last = cyc_n;
        end
        if (sync_err) se_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic d, input logic s);
        @(negedge clk);
        din        = d;
        frame_sync = s;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Slot i carries ch[i]; the parity slot (if present) follows the channels.
    task automatic send_frame(input logic [3:0] ch, input logic sync_end, input logic bad_par);
        logic [4:0] full;
        full = {(^ch) ^ bad_par, ch};
        for (int i = 0; i < FRAME; i++) begin
            tick(full[i/4], sync_end && (i == FRAME - 1));
            if (i == FRAME - 2) begin
                settle();
                chk("fv_before_boundary", frame_valid, 0);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        frame_sync = 1'b0;
        #12;
        chk("rst_ch_out", ch_out, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_parity_err", parity_err, 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        settle();
        chk("idle_unlocked", locked, 0);

        // Basic frame
        tick(1'b0, 1'b1);
        settle();
        chk("lock_on_sync", locked, 1);
        chk("no_err_idle_sync", sync_err, 0);
        base = fv_cnt;
        send_frame(4'b1101, 1'b1, 1'b0);
        settle();
        chk("basic_ch_out", ch_out, 4'b1101);
        chk("basic_fv", frame_valid, 1);
        chk("basic_fv_count", fv_cnt - base, 1);
        chk("basic_no_sync_err", sync_err, 0);

        // Back-to-back frames
        base = fv_cnt;
        send_frame(4'b0110, 1'b1, 1'b0);
        settle();
        chk("b2b1_ch_out", ch_out, 4'b0110);
        send_frame(4'b1010, 1'b1, 1'b0);
        settle();
        chk("b2b2_ch_out", ch_out, 4'b1010);
        send_frame(4'b0001, 1'b1, 1'b0);
        settle();
        chk("b2b3_ch_out", ch_out, 4'b0001);
        chk("b2b_fv_count", fv_cnt - base, 3);
        chk("b2b_spacing", fv_last - fv_prev, FRAME);
        chk("b2b_no_err", se_cnt, 0);
        chk("b2b_locked", locked, 1);

        // Early sync at slot 2, cyc 1
        for (int i = 0; i < 9; i++) tick(i < 8, 1'b0);
        tick(1'b0, 1'b1);
        settle();
        chk("early_sync_err", sync_err, 1);
        chk("early_ch_hold", ch_out, 4'b0001);
        chk("early_locked", locked, 1);
        chk("early_no_fv", frame_valid, 0);
        send_frame(4'b0011, 1'b1, 1'b0);
        settle();
        chk("after_early_ch_out", ch_out, 4'b0011);
        chk("after_early_fv", frame_valid, 1);

        // Flywheel: two consecutive missing syncs
        send_frame(4'b0101, 1'b0, 1'b0);
        settle();
        chk("miss1_ch_out", ch_out, 4'b0101);
        chk("miss1_fv", frame_valid, 1);
        chk("miss1_locked", locked, 1);
        send_frame(4'b1110, 1'b0, 1'b0);
        settle();
        chk("miss2_ch_out", ch_out, 4'b1110);
        chk("miss2_fv", frame_valid, 1);
        chk("miss2_unlocked", locked, 0);
        base = fv_cnt;
        send_frame(4'b1111, 1'b0, 1'b0);
        settle();
        chk("unlocked_no_fv", fv_cnt - base, 0);
        chk("unlocked_ch_hold", ch_out, 4'b1110);
        tick(1'b0, 1'b1);
        settle();
        chk("relock_no_sync_err", sync_err, 0);
        chk("relock_locked", locked, 1);

        // Reset mid-frame (during slot 1)
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ch_out", ch_out, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_fv", frame_valid, 0);
        chk("midrst_sync_err", sync_err, 0);
        chk("midrst_parity_err", parity_err, 0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        base = fv_cnt;
        send_frame(4'b1111, 1'b1, 1'b0);
        settle();
        chk("postrst_no_fv", fv_cnt - base, 0);
        chk("postrst_locked", locked, 1);
        send_frame(4'b1011, 1'b1, 1'b0);
        settle();
        chk("postrst_ch_out", ch_out, 4'b1011);
        chk("postrst_fv", frame_valid, 1);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(4'b1101, 1'b1, 1'b0);
        settle();
        chk("par_good_ch_out", ch_out, 4'b1101);
        chk("par_good_fv", frame_valid, 1);
        send_frame(4'b0110, 1'b1, 1'b1);
        settle();
        chk("par_bad_err", parity_err, 1);
        chk("par_bad_no_fv", frame_valid, 0);
        chk("par_bad_ch_hold", ch_out, 4'b1101);
        chk("par_bad_locked", locked, 1);
        chk("par_err_count", pe_cnt, 1);
`else
        chk("parity_tied_low", pe_cnt, 0);
`endif

        chk("total_sync_err", se_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
